// File: rtl/muladd_acc_if.sv
// Request/result bundle for the multi-channel multiply-accumulate engine.
// The master issues requests and consumes results; the slave is the engine.
interface muladd_acc_if #(
  parameter int AB_W = 16,
  parameter int ACC_W = 32,
  parameter int CH_W = 2
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_op;
  logic [CH_W-1:0]  in_ch;
  logic [AB_W-1:0]  in_a;
  logic [AB_W-1:0]  in_b;
  logic [ACC_W-1:0] in_c;
  logic             out_valid;
  logic             out_ready;
  logic [CH_W-1:0]  out_ch;
  logic [ACC_W-1:0] out_data;
  logic             out_sat;

  modport master (
    output in_valid, in_op, in_ch, in_a, in_b, in_c, out_ready,
    input  in_ready, out_valid, out_ch, out_data, out_sat
  );

  modport slave (
    input  in_valid, in_op, in_ch, in_a, in_b, in_c, out_ready,
    output in_ready, out_valid, out_ch, out_data, out_sat
  );
endinterface

// File: rtl/muladd_acc.sv
// Two-stage pipelined signed multiply-accumulate engine with CHANNELS independent
// accumulators, valid/ready handshake on both sides and optional result clipping.
module muladd_acc #(
  parameter int AB_W     = 16,
  parameter int ACC_W    = 32,
  parameter int CHANNELS = 4,
  parameter int SATURATE = 1
) (
  input logic         clk,
  input logic         rst_n,
  muladd_acc_if.slave bus
);
  localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int P_W  = 2 * AB_W;
  localparam int R_W  = ACC_W + 2;

  typedef enum logic [1:0] {
    OP_MAC  = 2'b00,
    OP_MSC  = 2'b01,
    OP_LOAD = 2'b10,
    OP_READ = 2'b11
  } op_e;

  logic                    s1_valid_r;
  op_e                     s1_op_r;
  logic [CH_W-1:0]         s1_ch_r;
  logic signed [AB_W-1:0]  s1_a_r;
  logic signed [AB_W-1:0]  s1_b_r;
  logic signed [ACC_W-1:0] s1_c_r;
  logic signed [ACC_W-1:0] acc_r [CHANNELS];

  logic                    out_valid_r;
  logic [CH_W-1:0]         out_ch_r;
  logic [ACC_W-1:0]        out_data_r;
  logic                    out_sat_r;

  logic                    adv_s;
  logic                    ch_ok_s;
  logic                    wr_s;
  logic                    ovf_s;
  logic signed [P_W-1:0]   prod_s;
  logic signed [ACC_W-1:0] acc_cur_s;
  logic signed [R_W-1:0]   r_s;
  logic signed [ACC_W-1:0] res_s;

  // Returns {clipped, value}: the top three bits of r agree exactly when r fits ACC_W.
  function automatic logic [ACC_W:0] clip_fn(input logic signed [R_W-1:0] r);
    logic fits;
    fits = (r[R_W-1:ACC_W-1] == 3'b000) || (r[R_W-1:ACC_W-1] == 3'b111);
    if (fits || (SATURATE == 0)) begin
      return {1'b0, r[ACC_W-1:0]};
    end else if (r[R_W-1]) begin
      return {1'b1, 1'b1, {(ACC_W-1){1'b0}}};
    end else begin
      return {1'b1, 1'b0, {(ACC_W-1){1'b1}}};
    end
  endfunction

  // Datapath for the request held in S1: select accumulator, multiply, combine, clip.
  always_comb begin
    adv_s     = !out_valid_r || bus.out_ready;
    prod_s    = P_W'(s1_a_r) * P_W'(s1_b_r);
    acc_cur_s = '0;
    ch_ok_s   = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      acc_cur_s = (s1_ch_r == CH_W'(i)) ? acc_r[i] : acc_cur_s;
      ch_ok_s   = ch_ok_s | (s1_ch_r == CH_W'(i));
    end
    if (ch_ok_s) begin
      case (s1_op_r)
        OP_MAC:  r_s = R_W'(acc_cur_s) + R_W'(prod_s);
        OP_MSC:  r_s = R_W'(acc_cur_s) - R_W'(prod_s);
        OP_LOAD: r_s = R_W'(s1_c_r) + R_W'(prod_s);
        OP_READ: r_s = R_W'(acc_cur_s);
        default: r_s = R_W'(acc_cur_s);
      endcase
    end else begin
      // Out-of-range channel behaves as a READ of a zero accumulator.
      r_s = '0;
    end
    wr_s           = ch_ok_s && (s1_op_r != OP_READ);
    {ovf_s, res_s} = clip_fn(r_s);
  end

  // Pipeline advance: S1 captures the new request, S2 and the accumulator update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_r  <= 1'b0;
      s1_op_r     <= OP_MAC;
      s1_ch_r     <= '0;
      s1_a_r      <= '0;
      s1_b_r      <= '0;
      s1_c_r      <= '0;
      out_valid_r <= 1'b0;
      out_ch_r    <= '0;
      out_data_r  <= '0;
      out_sat_r   <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) begin
        acc_r[i] <= '0;
      end
    end else if (adv_s) begin
      s1_valid_r  <= bus.in_valid;
      out_valid_r <= s1_valid_r;
      if (bus.in_valid) begin
        s1_op_r <= op_e'(bus.in_op);
        s1_ch_r <= bus.in_ch;
        s1_a_r  <= bus.in_a;
        s1_b_r  <= bus.in_b;
        s1_c_r  <= bus.in_c;
      end
      if (s1_valid_r) begin
        out_ch_r   <= s1_ch_r;
        out_data_r <= res_s;
        out_sat_r  <= ovf_s;
        for (int i = 0; i < CHANNELS; i++) begin
          if (wr_s && (s1_ch_r == CH_W'(i))) begin
            acc_r[i] <= res_s;
          end
        end
      end
    end
  end

  assign bus.in_ready  = adv_s;
  assign bus.out_valid = out_valid_r;
  assign bus.out_ch    = out_ch_r;
  assign bus.out_data  = out_data_r;
  assign bus.out_sat   = out_sat_r;
endmodule
